bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master (LSU over IFU) to one-slave bus arbiter, one transaction in flight at a time.
// Optional response timeout with error response is built when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [7:0]  lsu_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        IFU_REQ,
        IFU_RESP,
        LSU_REQ,
        LSU_RESP
`ifdef BUS_ARBITER_TIMEOUT_EN
        , ERR_RESP
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic        gnt_lsu_q, gnt_lsu_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [16:0] cnt_inc;
    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        gnt_lsu_d = gnt_lsu_q;
        cnt_d     = 16'd0;
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (lsu_req_valid) begin
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    state_d = LSU_REQ;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    gnt_lsu_d = 1'b1;
`endif
                end else if (ifu_req_valid) begin
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = 32'h0;
                    wmask_d = 8'h00;
                    state_d = IFU_REQ;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    gnt_lsu_d = 1'b0;
`endif
                end
            end
            IFU_REQ:  if (mem_req_ready) state_d = IFU_RESP;
            LSU_REQ:  if (mem_req_ready) state_d = LSU_RESP;
            IFU_RESP, LSU_RESP: begin
                if (mem_resp_valid && mem_resp_ready) state_d = IDLE;
`ifdef BUS_ARBITER_TIMEOUT_EN
                // Count only cycles with no response at all; a stalled master does not time out.
                cnt_d = cnt_q;
                if (!mem_resp_valid) begin
                    cnt_d = cnt_inc[15:0];
                    if (cnt_inc >= 17'(TIMEOUT_CYCLES)) begin
                        state_d = ERR_RESP;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            ERR_RESP: if (gnt_lsu_q ? lsu_resp_ready : ifu_resp_ready) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wen_q   <= 1'b0;
            wdata_q <= 32'h0;
            wmask_q <= 8'h00;
`ifdef BUS_ARBITER_TIMEOUT_EN
            gnt_lsu_q <= 1'b0;
            cnt_q     <= 16'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            gnt_lsu_q <= gnt_lsu_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

    always_comb begin
        lsu_req_ready  = (state_q == IDLE);
        ifu_req_ready  = (state_q == IDLE) && !lsu_req_valid;
        mem_req_valid  = (state_q == IFU_REQ) || (state_q == LSU_REQ);
        ifu_resp_valid = 1'b0;
        ifu_rdata      = 32'h0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = 32'h0;
        mem_resp_ready = 1'b0;
        case (state_q)
            IFU_RESP: begin
                ifu_resp_valid = mem_resp_valid;
                ifu_rdata      = mem_rdata;
                mem_resp_ready = ifu_resp_ready;
            end
            LSU_RESP: begin
                lsu_resp_valid = mem_resp_valid;
                lsu_rdata      = mem_rdata;
                mem_resp_ready = lsu_resp_ready;
            end
`ifdef BUS_ARBITER_TIMEOUT_EN
            ERR_RESP: begin
                ifu_resp_valid = !gnt_lsu_q;
                lsu_resp_valid = gnt_lsu_q;
            end
`endif
            default: ;
        endcase
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: IFU read, LSU priority, store with slave stall,
// master response stall, reset mid-transaction, and response timeout (or its absence).
module tb_bus_arbiter;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_rdata;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs set afterwards apply to the next edge, outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; lsu_resp_ready = 1;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        tick(); tick();
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (mem_resp_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_resp_ready got=%b exp=0", mem_resp_ready); end
        checks++; if ({ifu_resp_valid, lsu_resp_valid, timeout_err} !== 3'b000) begin failures++; $display("FAIL rst_resp_err got=%b exp=000", {ifu_resp_valid, lsu_resp_valid, timeout_err}); end
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b11) begin failures++; $display("FAIL rst_idle_readys got=%b exp=11", {lsu_req_ready, ifu_req_ready}); end
        checks++; if (mem_addr !== 32'h0 || mem_wmask !== 8'h0) begin failures++; $display("FAIL rst_captured got=%h/%h exp=0/0", mem_addr, mem_wmask); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL ifu_c0_ready got=%b exp=1", ifu_req_ready); end
        tick(); // cycle 1
        ifu_req_valid = 0; ifu_addr = 32'h0; mem_req_ready = 1;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000) begin failures++; $display("FAIL ifu_c1_req got=%b/%h exp=1/80000000", mem_req_valid, mem_addr); end
        checks++; if (mem_wen !== 1'b0 || mem_wmask !== 8'h00) begin failures++; $display("FAIL ifu_c1_wen_wmask got=%b/%h exp=0/00", mem_wen, mem_wmask); end
        checks++; if (ifu_req_ready !== 1'b0 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL ifu_c1_readys got=%b%b exp=00", ifu_req_ready, lsu_req_ready); end
        tick(); // cycle 2
        mem_req_ready = 0;
        checks++; if (mem_req_valid !== 1'b0 || ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL ifu_c2_wait got=%b%b exp=00", mem_req_valid, ifu_resp_valid); end
        checks++; if (mem_resp_ready !== 1'b1) begin failures++; $display("FAIL ifu_c2_mem_resp_ready got=%b exp=1", mem_resp_ready); end
        tick(); // cycle 3
        mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
        #1;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0413) begin failures++; $display("FAIL ifu_c3_resp got=%b/%h exp=1/00000413", ifu_resp_valid, ifu_rdata); end
        checks++; if (lsu_resp_valid !== 1'b0 || lsu_rdata !== 32'h0) begin failures++; $display("FAIL ifu_c3_lsu_quiet got=%b/%h exp=0/0", lsu_resp_valid, lsu_rdata); end
        tick(); // cycle 4
        mem_resp_valid = 0; mem_rdata = 32'h0;
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL ifu_c4_idle got=%b exp=1", lsu_req_ready); end
    endtask

    task automatic test_priority();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; lsu_wmask = 8'h00; lsu_wdata = 32'h0;
        #1;
        checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin failures++; $display("FAIL prio_readys got=%b exp=10", {lsu_req_ready, ifu_req_ready}); end
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        checks++; if (mem_addr !== 32'h8000_0200) begin failures++; $display("FAIL prio_lsu_first got=%h exp=80000200", mem_addr); end
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (lsu_resp_valid !== 1'b1 || lsu_rdata !== 32'h1234_5678 || ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL prio_lsu_resp got=%b/%h/%b exp=1/12345678/0", lsu_resp_valid, lsu_rdata, ifu_resp_valid); end
        checks++; if (ifu_req_ready !== 1'b0) begin failures++; $display("FAIL prio_ifu_pending got=%b exp=0", ifu_req_ready); end
        tick(); // first IDLE cycle after the LSU handshake
        mem_resp_valid = 0;
        #1;
        checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL prio_ifu_grant got=%b exp=1", ifu_req_ready); end
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0100) begin failures++; $display("FAIL prio_ifu_req got=%b/%h exp=1/80000100", mem_req_valid, mem_addr); end
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0bad_f00d;
        tick();
        mem_resp_valid = 0;
    endtask

    task automatic test_store_stall();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hdead_beef; lsu_wmask = 8'h0F;
        tick();
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = (i == 3);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1 ||
                mem_wdata !== 32'hdead_beef || mem_wmask !== 8'h0F || ifu_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL store_hold[%0d] got=%b/%h/%b/%h/%h/%b exp=1/80001000/1/deadbeef/0f/0", i,
                         mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_resp_valid);
            end
            tick();
        end
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hcafe_f00d; lsu_resp_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (mem_resp_ready !== 1'b0 || lsu_resp_valid !== 1'b1 || ifu_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL resp_stall[%0d] got=%b/%b/%b exp=0/1/0", i, mem_resp_ready, lsu_resp_valid, ifu_resp_valid);
            end
            tick();
        end
        lsu_resp_ready = 1;
        #1;
        checks++; if (mem_resp_ready !== 1'b1 || lsu_rdata !== 32'hcafe_f00d) begin failures++; $display("FAIL store_resp got=%b/%h exp=1/cafef00d", mem_resp_ready, lsu_rdata); end
        tick();
        mem_resp_valid = 0;
        checks++; if (lsu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL store_idle got=%b/%b exp=1/0", lsu_req_ready, ifu_resp_valid); end
    endtask

    task automatic test_reset_midflight();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h5555_aaaa; ifu_resp_ready = 0;
        #1;
        checks++; if (ifu_resp_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b exp=1", ifu_resp_valid); end
        rst = 1;
        #1;
        checks++;
        if (ifu_resp_valid !== 1'b0 || ifu_rdata !== 32'h0 || mem_resp_ready !== 1'b0 ||
            mem_req_valid !== 1'b0 || mem_addr !== 32'h0 || lsu_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_outputs got=%b/%h/%b/%b/%h/%b exp=0/0/0/0/0/1", ifu_resp_valid, ifu_rdata,
                     mem_resp_ready, mem_req_valid, mem_addr, lsu_req_ready);
        end
        tick();
        rst = 0; mem_resp_valid = 0; ifu_resp_ready = 1;
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0044;
        #1;
        checks++; if (ifu_req_ready !== 1'b1) begin failures++; $display("FAIL midrst_regrant got=%b exp=1", ifu_req_ready); end
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0044) begin failures++; $display("FAIL midrst_req got=%b/%h exp=1/80000044", mem_req_valid, mem_addr); end
        tick();
        mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'h0000_0013;
        #1;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0013) begin failures++; $display("FAIL midrst_resp got=%b/%h exp=1/00000013", ifu_resp_valid, ifu_rdata); end
        tick();
        mem_resp_valid = 0;
    endtask

    task automatic test_timeout();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick(); // first IFU_RESP cycle
        mem_req_ready = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            checks++; if (ifu_resp_valid !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] got=%b/%b exp=0/0", i, ifu_resp_valid, timeout_err); end
            tick();
        end
        ifu_resp_ready = 0;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0 || timeout_err !== 1'b1 || lsu_resp_valid !== 1'b0) begin failures++; $display("FAIL to_err got=%b/%h/%b/%b exp=1/0/1/0", ifu_resp_valid, ifu_rdata, timeout_err, lsu_resp_valid); end
        tick();
        ifu_resp_ready = 1;
        checks++; if (ifu_resp_valid !== 1'b1 || timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_once got=%b/%b exp=1/0", ifu_resp_valid, timeout_err); end
        tick();
        checks++; if (lsu_req_ready !== 1'b1 || ifu_resp_valid !== 1'b0) begin failures++; $display("FAIL to_idle got=%b/%b exp=1/0", lsu_req_ready, ifu_resp_valid); end
`else
        for (int i = 0; i < 20; i++) begin
            checks++; if (ifu_resp_valid !== 1'b0 || timeout_err !== 1'b0 || lsu_req_ready !== 1'b0) begin failures++; $display("FAIL nto_wait[%0d] got=%b/%b/%b exp=0/0/0", i, ifu_resp_valid, timeout_err, lsu_req_ready); end
            tick();
        end
        mem_resp_valid = 1; mem_rdata = 32'h7777_0001;
        #1;
        checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h7777_0001) begin failures++; $display("FAIL nto_late_resp got=%b/%h exp=1/77770001", ifu_resp_valid, ifu_rdata); end
        tick();
        mem_resp_valid = 0;
        checks++; if (lsu_req_ready !== 1'b1) begin failures++; $display("FAIL nto_idle got=%b exp=1", lsu_req_ready); end
`endif
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_priority();
        test_store_stall();
        test_reset_midflight();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
